// File: rtl/reg_arb_pkg.sv
// Shared types for the register write arbiter: FSM state encoding.
package reg_arb_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        LOCKED = 2'd2
    } state_e;

endpackage

// File: rtl/reg_en_dw.sv
// DW-wide register with synchronous active-high reset and load enable.
module reg_en_dw #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    logic [DW-1:0] q_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else if (en) begin
            q_q <= d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/reg_wr_arb.sv
// Round-robin arbiter granting one of N_REQ requesters write access to a
// shared DW-bit register, with optional lock to hold ownership across cycles.
module reg_wr_arb
    import reg_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned DW    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         lock,
    input  logic [N_REQ*DW-1:0]      wdata,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic [DW-1:0]            q,
    output logic                     q_vld
);

    localparam int unsigned OW = $clog2(N_REQ);

    state_e           state_q;
    logic [N_REQ-1:0] gnt_q;
    logic [OW-1:0]    owner_q;
    logic [OW-1:0]    ptr_q;
    logic             q_vld_q;

    logic [OW-1:0]    win_d;
    logic             found;
    int unsigned      idx;
    logic             wr_en;
    logic [DW-1:0]    wr_data;

    // Search starts just after the last grantee so it has lowest priority.
    always_comb begin
        win_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx = (32'(ptr_q) + i) % N_REQ;
            if (!found && req[OW'(idx)]) begin
                found = 1'b1;
                win_d = OW'(idx);
            end
        end
    end

    assign wr_en   = !rst && (state_q != IDLE) && req[owner_q];
    assign wr_data = wdata[owner_q*DW +: DW];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= OW'(N_REQ - 1);
            q_vld_q <= 1'b0;
        end else begin
            q_vld_q <= wr_en;
            case (state_q)
                IDLE: begin
                    if (found) begin
                        state_q <= GRANT;
                        gnt_q   <= {{(N_REQ-1){1'b0}}, 1'b1} << win_d;
                        owner_q <= win_d;
                        ptr_q   <= win_d;
                    end
                end
                GRANT, LOCKED: begin
                    if (lock[owner_q]) begin
                        state_q <= LOCKED;
                    end else begin
                        state_q <= IDLE;
                        gnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    reg_en_dw #(
        .DW(DW)
    ) u_reg (
        .clk(clk),
        .rst(rst),
        .en (wr_en),
        .d  (wr_data),
        .q  (q)
    );

    assign gnt   = gnt_q;
    assign owner = owner_q;
    assign q_vld = q_vld_q;

endmodule

// File: tb/tb_reg_wr_arb.sv
// Directed and random checks of reg_wr_arb with N_REQ=4, DW=8.
module tb_reg_wr_arb;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] lock;
    logic [N*W-1:0] wdata;
    logic [N-1:0] gnt;
    logic [1:0]   owner;
    logic [W-1:0] q;
    logic         q_vld;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reg_wr_arb #(
        .N_REQ(N),
        .DW   (W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .lock (lock),
        .wdata(wdata),
        .gnt  (gnt),
        .owner(owner),
        .q    (q),
        .q_vld(q_vld)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [N-1:0] prev_g;
    int           waitc [N];

    initial begin
        rst = 1'b1; req = '0; lock = '0; wdata = '0;
        step; step;
        chk("rst_gnt",   32'(gnt),   0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_q",     32'(q),     0);
        chk("rst_qvld",  32'(q_vld), 0);

        // all requesting, no locks: 0,1,2,3,0 with IDLE between
        rst = 1'b0; req = 4'b1111; wdata = 32'h13121110;
        for (int k = 0; k < 5; k++) begin
            step;
            chk("rr_gnt",   32'(gnt),   32'(1 << (k % 4)));
            chk("rr_owner", 32'(owner), 32'(k % 4));
            step;
            chk("rr_idle",  32'(gnt),   0);
            chk("rr_q",     32'(q),     32'('h10 + (k % 4)));
            chk("rr_qvld",  32'(q_vld), 1);
        end
        req = '0;
        step;
        chk("quiet_gnt",  32'(gnt),   0);
        chk("quiet_qvld", 32'(q_vld), 0);

        // single request on 2: latency check
        req = 4'b0100; wdata = 32'h00A50000;
        step;
        chk("p2_gnt",   32'(gnt),   'h4);
        chk("p2_owner", 32'(owner), 2);
        step;
        req = '0;
        chk("p2_q",     32'(q),     'hA5);
        chk("p2_qvld",  32'(q_vld), 1);
        chk("p2_idle",  32'(gnt),   0);
        step;
        chk("p2_qvld0", 32'(q_vld), 0);
        chk("p2_hold",  32'(q),     'hA5);

        // locked owner 1 while 3 (and others) toggle
        req = 4'b0010; lock = 4'b0010; wdata = 32'hCC000001;
        step;
        chk("lk_gnt0", 32'(gnt), 'h2);
        for (int k = 1; k <= 5; k++) begin
            req  = {1'b1, 1'b0, 1'b1, 1'(k % 2)};
            lock = {1'(k % 2), 1'b0, 1'b1, 1'b0};
            wdata[1*W +: W] = 8'(k);
            step;
            chk("lk_gnt",  32'(gnt),   'h2);
            chk("lk_q",    32'(q),     32'(k));
            chk("lk_qvld", 32'(q_vld), 1);
        end
        req = 4'b1000; lock = 4'b1000;
        step;
        chk("lk_exit",  32'(gnt),   0);
        chk("lk_hold",  32'(q),     5);
        chk("lk_qvld0", 32'(q_vld), 0);
        lock = '0;
        step;
        chk("lk_next",  32'(gnt),   'h8);
        chk("lk_nown",  32'(owner), 3);
        req = '0;
        step;
        chk("g3_nowr_q",    32'(q),     5);
        chk("g3_nowr_qvld", 32'(q_vld), 0);

        // grant to 0, request dropped during GRANT: no write
        req = 4'b0001; wdata = 32'h000000EE;
        step;
        chk("d0_gnt", 32'(gnt), 'h1);
        req = '0;
        step;
        chk("d0_idle", 32'(gnt),   0);
        chk("d0_q",    32'(q),     5);
        chk("d0_qvld", 32'(q_vld), 0);

        // reset in LOCKED aborts ownership
        req = 4'b0100; lock = 4'b0100; wdata = 32'h00770000;
        step;
        chk("rl_gnt", 32'(gnt), 'h4);
        step;
        chk("rl_lgnt", 32'(gnt), 'h4);
        chk("rl_q",    32'(q),   'h77);
        rst = 1'b1;
        step;
        chk("rl_gnt0",  32'(gnt),   0);
        chk("rl_q0",    32'(q),     0);
        chk("rl_qvld0", 32'(q_vld), 0);
        chk("rl_own0",  32'(owner), 0);
        rst = 1'b0; req = 4'b1001; lock = '0;
        step;
        chk("rl_first",  32'(gnt),   'h1);
        chk("rl_fowner", 32'(owner), 0);
        req = '0;
        step;
        chk("rl_end", 32'(gnt), 0);

        // random stress: one-hot grant and bounded wait in grants
        rst = 1'b1; req = '0; lock = '0;
        step;
        rst = 1'b0;
        prev_g = '0;
        for (int i = 0; i < int'(N); i++) waitc[i] = 0;
        repeat (10000) begin
            for (int i = 0; i < int'(N); i++) begin
                if (gnt[i]) begin
                    req[i]  = 1'($urandom_range(0, 1));
                    lock[i] = ($urandom_range(0, 2) == 0);
                end else if (!req[i]) begin
                    req[i]  = ($urandom_range(0, 3) == 0);
                    lock[i] = 1'($urandom_range(0, 1));
                end else begin
                    lock[i] = 1'($urandom_range(0, 1));
                end
                if (!req[i]) waitc[i] = 0;
            end
            wdata = $urandom;
            step;
            chk("st_onehot", 32'($onehot0(gnt)), 1);
            if (gnt != '0 && prev_g == '0) begin
                for (int j = 0; j < int'(N); j++) begin
                    if (gnt[j]) begin
                        chk("st_wait", 32'(waitc[j] <= int'(N) - 1), 1);
                        waitc[j] = 0;
                    end else if (req[j]) begin
                        waitc[j]++;
                    end
                end
            end
            prev_g = gnt;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_wr_arb.md
REG_WR_ARB -- requirements
Module: reg_wr_arb

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters; the block SHALL support 2..8.
REQ-002 Parameter DW, default 8: width of the shared register.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  N_REQ  per-requester write request, level, held until granted.
REQ-006 lock  input  N_REQ  per-requester hold; the owner keeps the register across cycles while its lock bit is high.
REQ-007 wdata  input  N_REQ*DW  per-requester write data; slice i = wdata[i*DW +: DW].
REQ-008 gnt  output  N_REQ  registered one-hot grant; all-zero when no owner.
REQ-009 owner  output  $clog2(N_REQ)  index of current/last grantee.
REQ-010 q  output  DW  shared register contents.
REQ-011 q_vld  output  1  one-cycle pulse in the cycle after q was written.

Function
REQ-012 FSM SHALL have exactly three states: IDLE, GRANT, LOCKED.
REQ-013 IDLE: no gnt bits set, no write; if any req bit is high, select winner w and enter GRANT next cycle.
REQ-014 Winner selection SHALL be round-robin: search indices ptr+1, ptr+2, ... modulo N_REQ; the first set req bit wins.
REQ-015 On entering GRANT: gnt = one-hot(w), owner = w, ptr = w, all registered at the same edge.
REQ-016 GRANT, single cycle: if req[w]=1, q loads wdata slice w at the end of the cycle; if req[w]=0, no write.
REQ-017 GRANT exit: lock[w]=1 goes to LOCKED; otherwise IDLE with gnt cleared. No back-to-back grant without a cycle in IDLE.
REQ-018 LOCKED: gnt stays one-hot(w); each cycle with req[w]=1 loads q from slice w; exit to IDLE when lock[w]=0, and that cycle's write still follows req[w].
REQ-019 Requests from non-owners SHALL be ignored in GRANT/LOCKED and arbitrated only from IDLE.
REQ-020 q_vld SHALL be 1 exactly in the cycle after each write, else 0.
REQ-021 q SHALL hold its value in every cycle without a write.
REQ-022 Latency: req rising in IDLE at cycle t means gnt at t+1, new q and q_vld at t+2.
REQ-023 Changes to lock/req of non-owners SHALL have no effect on an ongoing ownership.

Reset
REQ-024 While rst=1 at a clock edge: state=IDLE, gnt=0, owner=0, q=0, q_vld=0, ptr=N_REQ-1 (requester 0 has first priority).
REQ-025 Reset asserted in GRANT or LOCKED SHALL abort ownership at that edge; no write occurs in that cycle.
REQ-026 The first arbitration SHALL occur in the first cycle with rst=0.

Structure
REQ-027 State enum (IDLE/GRANT/LOCKED) and the state width constant SHALL be in shared package reg_arb_pkg.
REQ-028 The storage SHALL be a sub-module reg_en_dw, a DW-wide enabled register with synchronous active-high reset, driven by en = write-qualify and d = selected slice.
REQ-029 The round-robin search SHALL be combinational logic in reg_wr_arb; no other sub-modules.

Verification (N_REQ=4, DW=8)
REQ-030 After reset, req=4'b1111 with slices 0..3 = 8'h10,8'h11,8'h12,8'h13, lock=0, held: grants go 0,1,2,3,0 with one IDLE cycle between each, and q follows 10,11,12,13,10.
REQ-031 Single req[2] pulse, wdata[2]=8'hA5: gnt=4'b0100 at t+1, q=8'hA5 and q_vld=1 at t+2, q_vld=0 at t+3.
REQ-032 req[1]=1 and lock[1]=1 for 5 cycles with data 1..5, req[3] high throughout: gnt stays 4'b0010, q takes 1..5, then lock[1]=0 leads to IDLE and the next grant goes to 3.
REQ-033 GRANT to 0 with req[0] dropped in the GRANT cycle: q unchanged and q_vld stays 0.
REQ-034 rst=1 asserted mid-LOCKED: the next cycle shows gnt=0, q=0, q_vld=0; after release, req=4'b1001 grants 0 first.
REQ-035 Random req/lock stress for 10k cycles: gnt is always one-hot or zero, and no requester holding req waits more than N_REQ grants unless a lock is held.
